lane_sum_accumulator: RTL and testbench
=======================================

Name: lane_sum_accumulator

Overview:
Consumer end of the 8-lane streaming interface driven by the lane shift/feeder blocks. Each valid beat carries eight 8-bit samples. The block sums them through a 3-stage pipelined adder tree and accumulates BEATS valid beats into a frame total. At frame end it emits the total and the rounded mean (sum + 2^(AVG_SHIFT-1)) >> AVG_SHIFT with a one-cycle valid pulse.

Parameters:
BEATS, 32, valid beats per frame (2..2^21; 8*255*BEATS must fit in 32 bits)
AVG_SHIFT, 8, right shift for the mean (log2 of 8*BEATS at default)

Ports:
clk  input  1  clock, rising edge
rst  input  1  reset, synchronous, active-high
in_valid  input  1  beat qualifier; in0..in7 sampled only when high
in0..in7  input  8 each  unsigned lane samples
sum  output  32  frame total, held until the next frame completes
avg  output  32  rounded mean of frame, held with sum
sum_valid  output  1  one-cycle pulse when sum/avg update
busy  output  1  high while a partial frame or any pipeline stage holds valid data

Behaviour:
- Reset state, applied on any rising edge with rst high: sum=0, avg=0, sum_valid=0, busy=0, accumulator=0, beat counter=0, all stage valids=0.
- Reset mid-frame discards the partial frame and in-flight beats. No sum_valid is produced for the discarded data.
- Stage 1, at the sampling edge: four 9-bit pair sums (in0+in1, in2+in3, in4+in5, in6+in7) and v1=in_valid.
- Stage 2: two 10-bit sums, v2=v1.
- Stage 3: one 11-bit beat total, v3=v2.
- Stage 4, when v3=1:
  - The 11-bit beat total is zero-extended and added to the 32-bit accumulator.
  - The beat counter increments.
- When v3=1 and the counter equals BEATS-1 (frame end):
  - sum <= acc+beat
  - avg <= (acc + beat + 2^(AVG_SHIFT-1)) >> AVG_SHIFT, computed in 33 bits so there is no wrap.
  - sum_valid <= 1
  - accumulator <= 0 and counter <= 0 on the same edge.
- Latency: final beat presented in cycle k gives sum_valid high in cycle k+4, for exactly one cycle.
- sum_valid=0 in every other cycle.
- Bubbles: in_valid low cycles are ignored. Lane data is don't-care then, and stages may load it, but it is never accumulated. Only valid beats count toward BEATS.
- Back-to-back frames: the first beat of frame N+1 may immediately follow the last beat of frame N.
  - The restart is seamless: no lost beat and no extra bubble.
  - Pulses for full-rate frames are exactly BEATS cycles apart.
- The accumulator never overflows within the parameter limits. No saturation logic is present.
- busy = v1|v2|v3|(counter!=0), registered-equivalent, so it is 0 in the cycle after reset. busy drops in the cycle sum_valid rises if no new beats are pending.
- Fully pipelined: accepts one beat per cycle indefinitely. There is no backpressure and no ready signal.

Test Plan:
1. All lanes 255, 32 consecutive valid beats starting cycle 0 -> sum_valid only in cycle 35, sum=65280, avg=255.
2. in_i=i (0..7) for 32 beats -> beat total 28, sum=896, avg=4. sum/avg hold until the next frame.
3. All lanes 1, 32 valid beats with in_valid low every other cycle (garbage 0xFF on lanes when low) -> sum=256, avg=1, pulse 4 cycles after the 32nd valid beat.
4. Frame A all 255 directly followed by frame B all 0, 64 consecutive valid beats -> two single-cycle pulses 32 cycles apart: (65280,255) then (0,0).
5. 20 beats of 100, rst high 1 cycle, then 32 beats of 2 -> no pulse from the partial frame, one pulse with sum=512, avg=2. busy=0 in the cycle after rst.
6. Rounding boundary: 32 beats with in0=4, others 0 -> sum=128, avg=1. Repeat with in0=3 -> sum=96, avg=0.

Source files
------------

// File: rtl/lane_sum_accumulator_if.sv
// Eight-lane sample stream into the frame accumulator, plus its frame result outputs.
// The master drives the lanes; the slave (the accumulator) returns sum, avg, sum_valid and busy.
interface lane_sum_accumulator_if;
    logic        in_valid;
    logic [7:0]  in0;
    logic [7:0]  in1;
    logic [7:0]  in2;
    logic [7:0]  in3;
    logic [7:0]  in4;
    logic [7:0]  in5;
    logic [7:0]  in6;
    logic [7:0]  in7;
    logic [31:0] sum;
    logic [31:0] avg;
    logic        sum_valid;
    logic        busy;

    modport master (
        output in_valid, in0, in1, in2, in3, in4, in5, in6, in7,
        input  sum, avg, sum_valid, busy
    );

    modport slave (
        input  in_valid, in0, in1, in2, in3, in4, in5, in6, in7,
        output sum, avg, sum_valid, busy
    );
endinterface

// File: rtl/lane_sum_accumulator.sv
// Sums eight 8-bit lanes per valid beat through a 3-stage adder tree and accumulates
// BEATS valid beats into a frame total, emitting the total and rounded mean per frame.
module lane_sum_accumulator #(
    parameter int BEATS     = 32,
    parameter int AVG_SHIFT = 8
) (
    input logic                   clk,
    input logic                   rst,
    lane_sum_accumulator_if.slave bus
);
    localparam int CW = $clog2(BEATS);
    localparam logic [CW-1:0] LAST = CW'(BEATS - 1);
    localparam logic [32:0] HALF = 33'(1) << (AVG_SHIFT - 1);

    logic [8:0]    pair0, pair1, pair2, pair3;
    logic [9:0]    quad0, quad1;
    logic [10:0]   beat_total;
    logic          v1, v2, v3;
    logic [31:0]   acc;
    logic [CW-1:0] count;
    logic [31:0]   sum_r;
    logic [31:0]   avg_r;
    logic          sum_valid_r;
    logic [31:0]   acc_next;
    logic [32:0]   avg_full;

    // Tree data carries no reset; only the valid bits decide what gets accumulated.
    always_ff @(posedge clk) begin
        pair0      <= 9'(bus.in0) + 9'(bus.in1);
        pair1      <= 9'(bus.in2) + 9'(bus.in3);
        pair2      <= 9'(bus.in4) + 9'(bus.in5);
        pair3      <= 9'(bus.in6) + 9'(bus.in7);
        quad0      <= 10'(pair0) + 10'(pair1);
        quad1      <= 10'(pair2) + 10'(pair3);
        beat_total <= 11'(quad0) + 11'(quad1);
    end

    always_comb begin
        acc_next = acc + 32'(beat_total);
        avg_full = ({1'b0, acc_next} + HALF) >> AVG_SHIFT;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            v1          <= 1'b0;
            v2          <= 1'b0;
            v3          <= 1'b0;
            acc         <= '0;
            count       <= '0;
            sum_r       <= '0;
            avg_r       <= '0;
            sum_valid_r <= 1'b0;
        end else begin
            v1          <= bus.in_valid;
            v2          <= v1;
            v3          <= v2;
            sum_valid_r <= 1'b0;
            if (v3) begin
                if (count == LAST) begin
                    // Frame end: publish and restart on the same edge so the next beat is not lost.
                    sum_r       <= acc_next;
                    avg_r       <= avg_full[31:0];
                    sum_valid_r <= 1'b1;
                    acc         <= '0;
                    count       <= '0;
                end else begin
                    acc   <= acc_next;
                    count <= count + CW'(1);
                end
            end
        end
    end

    assign bus.sum       = sum_r;
    assign bus.avg       = avg_r;
    assign bus.sum_valid = sum_valid_r;
    assign bus.busy      = v1 | v2 | v3 | (count != '0);
endmodule

// File: tb/tb_lane_sum_accumulator.sv
// Randomized and directed stimulus for lane_sum_accumulator with a queue-based scoreboard
// fed by a frame-level reference model and drained by an independent output monitor.
module tb_lane_sum_accumulator;
    localparam int BEATS     = 32;
    localparam int AVG_SHIFT = 8;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    lane_sum_accumulator_if bus ();

    lane_sum_accumulator #(.BEATS(BEATS), .AVG_SHIFT(AVG_SHIFT)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    typedef struct {
        longint sum;
        longint avg;
        int     cycle;
    } expect_t;

    expect_t exp_q[$];
    int      checks   = 0;
    int      failures = 0;
    int      cyc      = 0;
    longint  model_sum;
    int      model_beats;

    always @(posedge clk) cyc++;

    task automatic check_output(input string name, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("[TB] FAIL %s: got %0d, expected %0d", name, act, req);
        end
    endtask

    // Reference model: a frame is simply the arithmetic total of BEATS valid beats.
    task automatic apply_stimulus(input logic valid, input logic [63:0] lanes);
        longint beat;
        @(negedge clk);
        bus.in_valid = valid;
        bus.in0 = lanes[7:0];
        bus.in1 = lanes[15:8];
        bus.in2 = lanes[23:16];
        bus.in3 = lanes[31:24];
        bus.in4 = lanes[39:32];
        bus.in5 = lanes[47:40];
        bus.in6 = lanes[55:48];
        bus.in7 = lanes[63:56];
        if (valid) begin
            beat = 0;
            for (int i = 0; i < 8; i++) beat += longint'(lanes[8*i +: 8]);
            model_sum += beat;
            model_beats++;
            if (model_beats == BEATS) begin
                exp_q.push_back('{model_sum, (model_sum + (64'd1 << (AVG_SHIFT - 1))) >> AVG_SHIFT, cyc + 4});
                model_sum   = 0;
                model_beats = 0;
            end
        end
    endtask

    task automatic send_frame(input logic [63:0] lanes, input int beats, input bit bubbles);
        for (int b = 0; b < beats; b++) begin
            apply_stimulus(1'b1, lanes);
            if (bubbles) apply_stimulus(1'b0, {8{8'hFF}});
        end
    endtask

    task automatic drain();
        int waited = 0;
        while (exp_q.size() != 0 && waited < 50) begin
            apply_stimulus(1'b0, {$urandom, $urandom});
            waited++;
        end
        repeat (2) apply_stimulus(1'b0, 64'd0);
        check_output("pending_frames", 64'(exp_q.size()), 64'd0);
        check_output("busy_idle", 64'(bus.busy), 64'd0);
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        bus.in_valid = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        model_sum   = 0;
        model_beats = 0;
        check_output("reset_sum", 64'(bus.sum), 64'd0);
        check_output("reset_avg", 64'(bus.avg), 64'd0);
        check_output("reset_sum_valid", 64'(bus.sum_valid), 64'd0);
        check_output("reset_busy", 64'(bus.busy), 64'd0);
    endtask

    // Monitor: every sum_valid pulse must match the oldest expected frame, on the expected cycle.
    initial begin
        forever begin
            @(posedge clk);
            #1;
            if (rst !== 1'b1 && bus.sum_valid === 1'b1) begin
                if (exp_q.size() == 0) begin
                    check_output("unexpected_pulse", 64'(bus.sum_valid), 64'd0);
                end else begin
                    expect_t e;
                    e = exp_q.pop_front();
                    check_output("frame_sum", 64'(bus.sum), 64'(e.sum));
                    check_output("frame_avg", 64'(bus.avg), 64'(e.avg));
                    check_output("pulse_cycle", 64'(cyc), 64'(e.cycle));
                end
            end
        end
    end

    initial begin
        rst = 1'b1;
        bus.in_valid = 1'b0;
        {bus.in0, bus.in1, bus.in2, bus.in3, bus.in4, bus.in5, bus.in6, bus.in7} = '0;
        model_sum   = 0;
        model_beats = 0;
        repeat (2) @(negedge clk);
        do_reset();

        send_frame({8{8'd255}}, BEATS, 1'b0);
        drain();
        check_output("t1_sum", 64'(bus.sum), 64'd65280);
        check_output("t1_avg", 64'(bus.avg), 64'd255);

        send_frame(64'h0706050403020100, BEATS, 1'b0);
        drain();
        check_output("t2_sum", 64'(bus.sum), 64'd896);
        check_output("t2_avg", 64'(bus.avg), 64'd4);
        send_frame({8{8'd9}}, 10, 1'b0);
        check_output("t2_hold_sum", 64'(bus.sum), 64'd896);
        check_output("t2_busy_mid", 64'(bus.busy), 64'd1);
        send_frame({8{8'd9}}, BEATS - 10, 1'b0);
        drain();

        send_frame({8{8'd1}}, BEATS, 1'b1);
        drain();
        check_output("t3_sum", 64'(bus.sum), 64'd256);
        check_output("t3_avg", 64'(bus.avg), 64'd1);

        send_frame({8{8'd255}}, BEATS, 1'b0);
        send_frame(64'd0, BEATS, 1'b0);
        drain();
        check_output("t4_sum", 64'(bus.sum), 64'd0);
        check_output("t4_avg", 64'(bus.avg), 64'd0);

        send_frame({8{8'd100}}, 20, 1'b0);
        do_reset();
        send_frame({8{8'd2}}, BEATS, 1'b0);
        drain();
        check_output("t5_sum", 64'(bus.sum), 64'd512);
        check_output("t5_avg", 64'(bus.avg), 64'd2);

        send_frame(64'd4, BEATS, 1'b0);
        drain();
        check_output("t6a_sum", 64'(bus.sum), 64'd128);
        check_output("t6a_avg", 64'(bus.avg), 64'd1);
        send_frame(64'd3, BEATS, 1'b0);
        drain();
        check_output("t6b_sum", 64'(bus.sum), 64'd96);
        check_output("t6b_avg", 64'(bus.avg), 64'd0);

        // Random frames with random bubbles, some back to back.
        for (int f = 0; f < 6; f++) begin
            int sent = 0;
            while (sent < BEATS) begin
                if ($urandom_range(99) < 70) begin
                    apply_stimulus(1'b1, {$urandom, $urandom});
                    sent++;
                end else begin
                    apply_stimulus(1'b0, {$urandom, $urandom});
                end
            end
        end
        drain();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
